// File: rtl/tile_query_arbiter.sv
// tile_query_arbiter: round-robin arbiter sharing one tile-map lookup port among four requesters.
// Define TILE_QUERY_LOCK_EN to compile in lock ownership with an idle timeout.
module tile_query_arbiter #(
    parameter int LOCK_TIMEOUT = 16,
    parameter int COORD_W = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           req,
    input  logic [4*COORD_W-1:0] req_x,
    input  logic [4*COORD_W-1:0] req_y,
    input  logic [3:0]           lock,
    output logic [3:0]           gnt,
    output logic [COORD_W-1:0]   tile_x,
    output logic [COORD_W-1:0]   tile_y,
    output logic                 tile_en,
    input  logic [2:0]           tile_type,
    output logic [3:0]           rsp_valid,
    output logic [2:0]           rsp_type
);
`ifdef TILE_QUERY_LOCK_EN
    localparam bit LockEn = 1'b1;
`else
    localparam bit LockEn = 1'b0;
`endif
    typedef enum logic {ARB, OWNED} state_t;
    state_t state, nextState;
    logic [1:0] ptr, nextPtr, owner, nextOwner, win, pendWin;
    logic [7:0] idleCnt, nextIdle;
    logic xfer;
    always_comb begin
        win = ptr;
        xfer = 1'b0;
        nextState = state;
        nextPtr = ptr;
        nextOwner = owner;
        nextIdle = idleCnt;
        for (int k = 0; k < 4; k++)
            if (!xfer && req[ptr + 2'(k)]) begin
                win = ptr + 2'(k);
                xfer = 1'b1;
            end
        if (state == OWNED) begin
            win = owner;
            xfer = req[owner];
        end
        gnt = xfer ? 4'b0001 << win : 4'b0000;
        if (state == ARB) begin
            if (xfer && lock[win] && LockEn) begin
                nextState = OWNED;
                nextOwner = win;
                nextIdle = '0;
            end else if (xfer)
                nextPtr = win + 2'd1;
        end else if (xfer) begin
            nextIdle = '0;
            nextState = lock[owner] ? OWNED : ARB;
            nextPtr = lock[owner] ? ptr : owner + 2'd1;
        end else if (idleCnt + 8'd1 == 8'(LOCK_TIMEOUT)) begin
            // owner went quiet too long: release so the others are not starved
            nextState = ARB;
            nextPtr = owner + 2'd1;
            nextIdle = '0;
        end else
            nextIdle = idleCnt + 8'd1;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= ARB;
            ptr <= '0;
            owner <= '0;
            idleCnt <= '0;
            tile_x <= '0;
            tile_y <= '0;
            tile_en <= 1'b0;
            pendWin <= '0;
            rsp_valid <= '0;
            rsp_type <= '0;
        end else begin
            state <= nextState;
            ptr <= nextPtr;
            owner <= nextOwner;
            idleCnt <= nextIdle;
            tile_en <= xfer;
            if (xfer) begin
                tile_x <= req_x[win*COORD_W +: COORD_W];
                tile_y <= req_y[win*COORD_W +: COORD_W];
                pendWin <= win;
            end
            rsp_valid <= tile_en ? 4'b0001 << pendWin : 4'b0000;
            if (tile_en)
                rsp_type <= tile_type;
        end
endmodule

// File: tb/tb_tile_query_arbiter.sv
// tb_tile_query_arbiter: directed vectors with a response scoreboard for tile_query_arbiter.
module tb_tile_query_arbiter;
    localparam int CW = 10;
    logic clk = 1'b0, rst_n = 1'b0, tile_en;
    logic [3:0] req = '0, lock = '0, gnt, rsp_valid;
    logic [4*CW-1:0] req_x, req_y;
    logic [CW-1:0] tile_x, tile_y;
    logic [2:0] tile_type, rsp_type;
    logic [CW-1:0] xs[4], ys[4];
    int cyc = 0, ntests = 0, nfail = 0;
    typedef struct {logic [3:0] v; logic [2:0] t; int at;} exp_t;
    exp_t q[$];

    tile_query_arbiter #(.LOCK_TIMEOUT(16), .COORD_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_x(req_x), .req_y(req_y), .lock(lock),
        .gnt(gnt), .tile_x(tile_x), .tile_y(tile_y), .tile_en(tile_en),
        .tile_type(tile_type), .rsp_valid(rsp_valid), .rsp_type(rsp_type)
    );

    function automatic logic [2:0] mapType(input logic [CW-1:0] x, input logic [CW-1:0] y);
        return (x == 10'd40 && y == 10'd100) ? 3'd1 : x[2:0] ^ y[2:0] ^ 3'd5;
    endfunction

    function automatic int oneIdx(input logic [3:0] g);
        for (int i = 0; i < 4; i++)
            if (g[i]) return i;
        return 0;
    endfunction

    assign tile_type = mapType(tile_x, tile_y);
    always_comb begin
        req_x = '0;
        req_y = '0;
        for (int i = 0; i < 4; i++) begin
            req_x[i*CW +: CW] = xs[i];
            req_y[i*CW +: CW] = ys[i];
        end
    end
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rsp_valid != 4'b0000) begin
            ntests++;
            if (q.size() == 0) begin
                nfail++;
                $display("FAIL rsp_unexpected: got valid=%b type=%0d at cyc %0d, required no response", rsp_valid, rsp_type, cyc);
            end else begin
                e = q.pop_front();
                if (rsp_valid !== e.v || rsp_type !== e.t || cyc != e.at) begin
                    nfail++;
                    $display("FAIL rsp: got valid=%b type=%0d cyc=%0d, required valid=%b type=%0d cyc=%0d", rsp_valid, rsp_type, cyc, e.v, e.t, e.at);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        ntests++;
        if (got !== expv) begin
            nfail++;
            $display("FAIL %s: got %0h, required %0h", name, got, expv);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] l, input logic [3:0] eg);
        int w;
        req = r;
        lock = l;
        @(negedge clk);
        chk("gnt", 32'(gnt), 32'(eg));
        if (eg != 4'b0000) begin
            w = oneIdx(eg);
            q.push_back('{v: eg, t: mapType(xs[w], ys[w]), at: cyc + 2});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        xs = '{10'd11, 10'd22, 10'd33, 10'd44};
        ys = '{10'd5, 10'd17, 10'd60, 10'd200};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tile_en", 32'(tile_en), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_tile_x", 32'(tile_x), 0);
        chk("rst_gnt_noreq", 32'(gnt), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(4'b1111, 4'b0000, 4'b0001 << i);
        step(4'b0000, 4'b0000, 4'b0000);
        step(4'b0000, 4'b0000, 4'b0000);
        xs[0] = 10'd40;
        ys[0] = 10'd100;
        step(4'b0101, 4'b0000, 4'b0001);
        chk("tile_x_40", 32'(tile_x), 40);
        chk("tile_y_100", 32'(tile_y), 100);
        chk("tile_en_live", 32'(tile_en), 1);
        step(4'b0101, 4'b0000, 4'b0100);
        step(4'b0000, 4'b0000, 4'b0000);
        chk("tile_en_idle", 32'(tile_en), 0);
        chk("tile_x_hold", 32'(tile_x), 32'(xs[2]));
        step(4'b1001, 4'b0000, 4'b1000);
        step(4'b0000, 4'b0000, 4'b0000);
`ifdef TILE_QUERY_LOCK_EN
        step(4'b0010, 4'b0010, 4'b0010);
        step(4'b1111, 4'b0010, 4'b0010);
        step(4'b1111, 4'b0010, 4'b0010);
        step(4'b1111, 4'b0000, 4'b0010);
        step(4'b1111, 4'b0000, 4'b0100);
        step(4'b1000, 4'b1000, 4'b1000);
        for (int i = 0; i < 16; i++) step(4'b0001, 4'b0000, 4'b0000);
        step(4'b0001, 4'b0000, 4'b0001);
`else
        step(4'b0011, 4'b1111, 4'b0001);
        step(4'b0011, 4'b1111, 4'b0010);
        step(4'b0011, 4'b1111, 4'b0001);
        step(4'b0011, 4'b1111, 4'b0010);
`endif
        step(4'b0000, 4'b0000, 4'b0000);
        step(4'b0000, 4'b0000, 4'b0000);
        step(4'b0100, 4'b0000, 4'b0100);
        req = 4'b0000;
        rst_n = 1'b0;
        #1;
        chk("rst_pulse_tile_en", 32'(tile_en), 0);
        chk("rst_pulse_tile_xy", 32'({tile_x, tile_y}), 0);
        chk("rst_pulse_rsp", 32'({rsp_valid, rsp_type}), 0);
        chk("rst_pulse_gnt", 32'(gnt), 0);
        q.delete();
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(4'b1111, 4'b0000, 4'b0001);
        repeat (3) step(4'b0000, 4'b0000, 4'b0000);
        chk("scoreboard_empty", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
